// File: rtl/acc_pkg.sv
// acc_pkg: shared offload types for the predecoder and its arbiter.
package acc_pkg;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic       p_accept;
        logic       p_is_mem_op;
        logic       p_writeback;
        logic [2:0] p_use_rs;
    } acc_prd_rsp_t;

    typedef enum logic [1:0] {IDLE, DECODE, RESP} acc_prd_arb_state_e;

endpackage

// File: rtl/acc_prd_rr_arb.sv
// acc_prd_rr_arb: combinational round-robin pick starting just above last_grant.
module acc_prd_rr_arb #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last_grant,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            any
);
    // Scan from the farthest candidate down to the nearest so the nearest wins.
    always_comb begin
        int k;
        gnt = '0;
        gnt_idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(last_grant) + 1 + i) % N;
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                gnt_idx = IdxW'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_prd_arbiter.sv
// acc_prd_arbiter: round-robin sharing of one predecoder among NumReq cores.
// Define ACC_PRD_ARB_PERF_EN to build the accept/reject performance counters.
module acc_prd_arbiter
    import acc_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int CntW   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic         [NumReq-1:0] q_valid_i,
    input  acc_prd_req_t [NumReq-1:0] q_req_i,
    output logic         [NumReq-1:0] q_ready_o,
    output logic         [NumReq-1:0] p_valid_o,
    output acc_prd_rsp_t              p_rsp_o,
    input  logic         [NumReq-1:0] p_ready_i,
    output acc_prd_req_t              prd_req_o,
    input  acc_prd_rsp_t              prd_rsp_i,
    output logic         [CntW-1:0]   perf_accept_o,
    output logic         [CntW-1:0]   perf_reject_o
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    acc_prd_arb_state_e state;
    acc_prd_req_t       req_q;
    acc_prd_rsp_t       rsp_q;
    logic [IdxW-1:0]    idx_q, last_grant, gnt_idx;
    logic [NumReq-1:0]  gnt;
    logic               any, p_done;

    acc_prd_rr_arb #(.N(NumReq), .IdxW(IdxW)) u_arb (
        .req        (q_valid_i),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign q_ready_o = (state == IDLE) ? gnt : '0;
    assign p_valid_o = (state == RESP) ? (NumReq'(1) << idx_q) : '0;
    assign p_rsp_o   = rsp_q;
    assign prd_req_o = req_q;
    assign p_done    = (state == RESP) && p_ready_i[idx_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= IdxW'(NumReq - 1);
            req_q      <= '0;
            idx_q      <= '0;
            rsp_q      <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    req_q      <= q_req_i[gnt_idx];
                    idx_q      <= gnt_idx;
                    last_grant <= gnt_idx;
                    state      <= DECODE;
                end
                DECODE: begin
                    rsp_q <= prd_rsp_i;
                    state <= RESP;
                end
                RESP: if (p_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACC_PRD_ARB_PERF_EN
    logic [CntW-1:0] acc_cnt, rej_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else if (p_done) begin
            if (rsp_q.p_accept) acc_cnt <= acc_cnt + CntW'(1);
            else rej_cnt <= rej_cnt + CntW'(1);
        end
    end

    assign perf_accept_o = acc_cnt;
    assign perf_reject_o = rej_cnt;
`else
    assign perf_accept_o = '0;
    assign perf_reject_o = '0;
`endif

endmodule

// File: tb/tb_acc_prd_arbiter.sv
// tb_acc_prd_arbiter: directed checks of grant order, latency, backpressure and counters.
module tb_acc_prd_arbiter;
    import acc_pkg::*;

    localparam acc_prd_rsp_t RSP_ACC  = '{p_accept: 1'b1, p_is_mem_op: 1'b0, p_writeback: 1'b1, p_use_rs: 3'b011};
    localparam acc_prd_rsp_t RSP_NONE = '0;
`ifdef ACC_PRD_ARB_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0] q_valid, q_ready, p_valid, p_ready, exp_g, exp_p;
    acc_prd_req_t [1:0] q_req;
    acc_prd_req_t prd_req;
    acc_prd_rsp_t p_rsp, prd_rsp;
    logic [31:0] perf_acc, perf_rej;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Stand-in predecoder: custom-0 opcode (0x0B) is an accelerator instruction.
    always_comb prd_rsp = (prd_req.q_instr_data[6:0] == 7'h0B) ? RSP_ACC : RSP_NONE;

    acc_prd_arbiter #(.NumReq(2), .CntW(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .q_valid_i     (q_valid),
        .q_req_i       (q_req),
        .q_ready_o     (q_ready),
        .p_valid_o     (p_valid),
        .p_rsp_o       (p_rsp),
        .p_ready_i     (p_ready),
        .prd_req_o     (prd_req),
        .prd_rsp_i     (prd_rsp),
        .perf_accept_o (perf_acc),
        .perf_reject_o (perf_rej)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        q_valid = '0;
        p_ready = '0;
        q_req = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_q_ready", 32'(q_ready), 32'h0);
        chk("rst_p_valid", 32'(p_valid), 32'h0);
        chk("rst_prd_req", 32'(prd_req), 32'h0);
        chk("rst_p_rsp", 32'(p_rsp), 32'h0);
        chk("rst_perf_acc", perf_acc, 32'h0);
        chk("rst_perf_rej", perf_rej, 32'h0);
        rst = 1'b0;
        // single request: grant at t, predecoder sees it at t+1, response at t+2
        @(negedge clk);
        q_valid = 2'b01;
        q_req[0].q_instr_data = 32'h0000_000B;
        #1 chk("t1_q_ready", 32'(q_ready), 32'h1);
        @(negedge clk);
        q_valid = '0;
        #1;
        chk("t1_prd_req", 32'(prd_req), 32'h0000_000B);
        chk("t1_q_ready_dec", 32'(q_ready), 32'h0);
        chk("t1_p_valid_dec", 32'(p_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_p_valid", 32'(p_valid), 32'h1);
        chk("t1_p_rsp", 32'(p_rsp), 32'(RSP_ACC));
        p_ready = 2'b01;
        @(negedge clk);
        p_ready = '0;
        #1 chk("t1_p_valid_done", 32'(p_valid), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // round robin with both cores busy
        q_valid = 2'b11;
        p_ready = 2'b11;
        q_req[0].q_instr_data = 32'h0000_010B;
        q_req[1].q_instr_data = 32'h0000_020B;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_g = (k % 3 == 0) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_p = (k % 3 == 2) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("t2_q_ready_%0d", k), 32'(q_ready), 32'(exp_g));
            chk($sformatf("t2_p_valid_%0d", k), 32'(p_valid), 32'(exp_p));
            @(negedge clk);
        end
        // backpressure on core 0 while core 1 asks
        q_valid = 2'b01;
        p_ready = '0;
        q_req[0].q_instr_data = 32'h0000_030B;
        #1 chk("t3_q_ready", 32'(q_ready), 32'h1);
        @(negedge clk);
        q_valid = '0;
        @(negedge clk);
        q_valid = 2'b10;
        q_req[1].q_instr_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t3_p_valid_%0d", k), 32'(p_valid), 32'h1);
            chk($sformatf("t3_p_rsp_%0d", k), 32'(p_rsp), 32'(RSP_ACC));
            chk($sformatf("t3_q_ready_%0d", k), 32'(q_ready), 32'h0);
            @(negedge clk);
        end
        p_ready = 2'b01;
        #1 chk("t3_p_valid_last", 32'(p_valid), 32'h1);
        @(negedge clk);
        // reject path on core 1
        #1;
        chk("t4_q_ready", 32'(q_ready), 32'h2);
        chk("t4_p_valid_idle", 32'(p_valid), 32'h0);
        @(negedge clk);
        q_valid = '0;
        #1 chk("t4_prd_req", 32'(prd_req), 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("t4_p_valid", 32'(p_valid), 32'h2);
        chk("t4_p_rsp", 32'(p_rsp), 32'(RSP_NONE));
        @(negedge clk);
        #1 chk("t4_ignore_other_ready", 32'(p_valid), 32'h2);
        p_ready = 2'b10;
        @(negedge clk);
        p_ready = '0;
        #1;
        chk("t4_perf_rej", perf_rej, PERF ? 32'd1 : 32'd0);
        chk("t4_perf_acc", perf_acc, PERF ? 32'd5 : 32'd0);
        // reset during DECODE of a core-0 grant
        q_valid = 2'b11;
        q_req[0].q_instr_data = 32'h0000_040B;
        q_req[1].q_instr_data = 32'h0000_050B;
        #1 chk("t5_q_ready", 32'(q_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        q_valid = '0;
        #1 chk("t5_prd_req_dec", 32'(prd_req), 32'h0000_040B);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_p_valid_after", 32'(p_valid), 32'h0);
        chk("t5_prd_req_after", 32'(prd_req), 32'h0);
        chk("t5_q_ready_after", 32'(q_ready), 32'h0);
        q_valid = 2'b11;
        p_ready = 2'b11;
        #1 chk("t5_first_grant", 32'(q_ready), 32'h1);
        @(negedge clk);
        q_valid = '0;
        @(negedge clk);
        #1 chk("t5_p_valid", 32'(p_valid), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        p_ready = '0;
        @(negedge clk);
        rst = 1'b0;
        // 10 accepted then 3 rejected
        for (int i = 0; i < 13; i++) begin
            q_valid = 2'b01;
            p_ready = 2'b01;
            q_req[0].q_instr_data = (i < 10) ? (32'h0000_000B | (32'(i) << 8)) : 32'hFFFF_FFFF;
            #1 chk($sformatf("t6_q_ready_%0d", i), 32'(q_ready), 32'h1);
            @(negedge clk);
            @(negedge clk);
            #1 chk($sformatf("t6_accept_%0d", i), 32'(p_rsp.p_accept), 32'(i < 10));
            @(negedge clk);
        end
        q_valid = '0;
        #1;
        chk("t6_perf_acc", perf_acc, PERF ? 32'd10 : 32'd0);
        chk("t6_perf_rej", perf_rej, PERF ? 32'd3 : 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
